uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that responds to the single-cycle core's data-side bus, i.e. the load/store path selected when the control unit asserts HADDR_Sel with MemWrite. Stores to its register window queue bytes into a one-entry holding register. An 8N1 serializer shifts them out on `tx`. Loads return status and configuration combinationally, so the core completes a load in its single cycle.

---
 rtl/uart_tx_mmio.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped UART transmitter for the single-cycle core's data bus.
// A store to TXDATA queues a byte in a one-entry holding register. The
// serializer then shifts the byte out on tx as 8N1, LSB first. Loads are
// answered combinationally, so a load completes in the core's single cycle.
//
// Register window (word offsets from BASE_ADDR, HADDR[1:0] ignored):
//   0x0 TXDATA  : write HWDATA[7:0] into the holding register; reads 0
//   0x4 STATUS  : {29'b0, overrun, hold_full, tx_busy}; write 1 to bit2 clears overrun
//   0x8 BAUDDIV : 16-bit divisor, bit period = BAUDDIV+1 clocks
//   0xC         : unmapped, writes ignored, reads 0
//
// Optional feature: define UART_PARITY_EN to insert an even-parity bit
// after the data bits, which gives an 11-bit frame.
//
// Parameters:
//   BASE_ADDR  byte address of the register window
//   DIV_RESET  reset value of BAUDDIV
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   HADDR     data address from the core
//   HWDATA    store data
//   MemWrite  store strobe
//   HRDATA    combinational read data, 0 outside the window
//   tx        serial output, idle high
//   tx_busy   high while a frame is being shifted
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter logic [15:0] DIV_RESET = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic        MemWrite,
   output logic [31:0] HRDATA,
   output logic        tx,
   output logic        tx_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        hold_full;
   logic [7:0]  hold_data;
   logic        overrun;
   logic [15:0] baud_div;
   logic [15:0] div_lat;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;

   logic        win_hit;
   logic [1:0]  reg_off;
   logic        wr_txdata;
   logic        wr_status;
   logic        wr_baud;
   logic        bit_end;
   logic        load_shift;
   logic        tx_accept;
   logic        unused_bits;

   // Address decode: the window spans 16 bytes, and offset 0xC decodes but
   // is unmapped.
   assign win_hit   = (HADDR[31:4] == BASE_ADDR[31:4]);
   assign reg_off   = HADDR[3:2];
   assign wr_txdata = MemWrite & win_hit & (reg_off == 2'd0);
   assign wr_status = MemWrite & win_hit & (reg_off == 2'd1);
   assign wr_baud   = MemWrite & win_hit & (reg_off == 2'd2);

   assign unused_bits = ^{HADDR[1:0], HWDATA[31:16]};

   assign bit_end = (baud_cnt == 16'd0);

   // The holding register is handed to the shifter when the line is idle.
   // It is also handed over in the last cycle of a stop bit, so that
   // back-to-back frames have no gap between them.
   assign load_shift = hold_full &
                       ((state == S_IDLE) | ((state == S_STOP) & bit_end));

   // A store is accepted if the slot is empty or is being emptied on this edge.
   assign tx_accept = ~hold_full | load_shift;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (hold_full) state_nx = S_START;
         end
         S_START: begin
            if (bit_end) state_nx = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
               state_nx = S_PARITY;
`else
               state_nx = S_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_nx = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) state_nx = hold_full ? S_START : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Output logic. The shifter rotates, so after eight data bits it holds
   // the original byte again, and the parity bit can be taken from it.
   always_comb begin
      tx      = 1'b1;
      tx_busy = (state != S_IDLE);
      case (state)
         S_START:  tx = 1'b0;
         S_DATA:   tx = shift_reg[0];
`ifdef UART_PARITY_EN
         S_PARITY: tx = ^shift_reg;
`endif
         default:  tx = 1'b1;
      endcase
   end

   // Control state: holding flag, overrun, divisor, bit timing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         overrun   <= 1'b0;
         baud_div  <= DIV_RESET;
         div_lat   <= DIV_RESET;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
      end else begin
         if (wr_txdata && tx_accept) begin
            hold_full <= 1'b1;
         end else if (load_shift) begin
            hold_full <= 1'b0;
         end

         if (wr_txdata && !tx_accept) begin
            overrun <= 1'b1;
         end else if (wr_status && HWDATA[2]) begin
            overrun <= 1'b0;
         end

         if (wr_baud) baud_div <= HWDATA[15:0];

         // The divisor is sampled once per frame. A BAUDDIV write in the
         // middle of a frame therefore only affects the next frame.
         if (load_shift) begin
            baud_cnt <= baud_div;
            div_lat  <= baud_div;
            bit_idx  <= 3'd0;
         end else if (state != S_IDLE) begin
            if (bit_end) begin
               baud_cnt <= div_lat;
               if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
            end else begin
               baud_cnt <= baud_cnt - 16'd1;
            end
         end
      end
   end

   // Data registers: no reset needed, their contents are qualified by control
   always_ff @(posedge clk) begin
      if (wr_txdata && tx_accept) hold_data <= HWDATA[7:0];
      if (load_shift) begin
         shift_reg <= hold_data;
      end else if ((state == S_DATA) && bit_end) begin
         shift_reg <= {shift_reg[0], shift_reg[7:1]};
      end
   end

   // Read mux
   always_comb begin
      HRDATA = 32'd0;
      if (win_hit) begin
         case (reg_off)
            2'd1:    HRDATA = {29'd0, overrun, hold_full, tx_busy};
            2'd2:    HRDATA = {16'd0, baud_div};
            default: HRDATA = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        MemWrite;
   logic [31:0] HRDATA;
   logic        tx;
   logic        tx_busy;

   uart_tx_mmio #(.BASE_ADDR(BASE), .DIV_RESET(16'd433)) dut (
      .clk      (clk),
      .rst      (rst),
      .HADDR    (HADDR),
      .HWDATA   (HWDATA),
      .MemWrite (MemWrite),
      .HRDATA   (HRDATA),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] data;
      int         period;
   } rx_exp_t;
   rx_exp_t sb[$];

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       nm;
   } vec_t;
   vec_t vt[13];

   logic exp_tx[$];
   int   runs[$];
   int   run_len = 0;
   logic rx_mute = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   function automatic void setv(input int i, input logic [31:0] a, input logic w,
                                input logic [31:0] d, input logic [31:0] e, input string nm);
      vt[i].addr  = a;
      vt[i].wr    = w;
      vt[i].wdata = d;
      vt[i].exp   = e;
      vt[i].nm    = nm;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      HADDR    = a;
      HWDATA   = d;
      MemWrite = 1'b1;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      HWDATA   = 32'd0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      HADDR = a;
      #1;
      check(nm, HRDATA, e);
   endtask

   task automatic send(input logic [7:0] b, input int p, input bit accept);
      rx_exp_t e;
      if (accept) begin
         e.data   = b;
         e.period = p;
         sb.push_back(e);
      end
      wr(BASE, {24'd0, b});
   endtask

   task automatic push_frame(input logic [7:0] b, input int p);
      repeat (p) exp_tx.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (p) exp_tx.push_back(b[i]);
`ifdef UART_PARITY_EN
      repeat (p) exp_tx.push_back(^b);
`endif
      repeat (p) exp_tx.push_back(1'b1);
   endtask

   task automatic check_wave(input string nm, input int exp_lat);
      int lat;
      int mism;
      int busy_c;
      int n;
      lat = 0;
      mism = 0;
      busy_c = 0;
      while (!tx_busy && lat < 20) begin
         step();
         lat++;
      end
      check({nm, "_latency"}, lat, exp_lat);
      n = exp_tx.size();
      for (int i = 0; i < n; i++) begin
         if (tx !== exp_tx[i]) mism++;
         if (tx_busy === 1'b1) busy_c++;
         step();
      end
      exp_tx.delete();
      check({nm, "_tx_mismatch_cycles"}, mism, 0);
      check({nm, "_busy_cycles"}, busy_c, n);
      check({nm, "_busy_after"}, tx_busy, 0);
      check({nm, "_tx_idle_after"}, tx, 1);
   endtask

   task automatic wait_idle(input string nm, input int limit);
      int k;
      k = 0;
      while (tx_busy && k < limit) begin
         step();
         k++;
      end
      check({nm, "_idle"}, tx_busy, 0);
   endtask

   task automatic get_run(input string nm, input int e);
      int r;
      @(negedge clk);
      #1;
      r = (runs.size() == 0) ? 0 : runs[runs.size() - 1];
      check(nm, r, e);
      runs.delete();
   endtask

   // Length of each contiguous tx_busy run, sampled on the falling edge
   always @(negedge clk) begin
      if (tx_busy === 1'b1) begin
         run_len++;
      end else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
   end

   // Serial receiver: samples each bit mid-period and compares against the scoreboard
   initial begin : rx_model
      rx_exp_t    e;
      logic [7:0] d;
      int         k;
      forever begin
         @(negedge clk);
         if (!rx_mute && rst === 1'b1 && tx === 1'b0) begin
            if (sb.size() == 0) begin
               check("rx_frame_expected", sb.size(), 1);
               k = 0;
               while (tx_busy && k < 4000) begin
                  @(negedge clk);
                  k++;
               end
            end else begin
               e = sb.pop_front();
               repeat (e.period / 2) @(negedge clk);
               check("rx_start_bit", tx, 0);
               for (int b = 0; b < 8; b++) begin
                  repeat (e.period) @(negedge clk);
                  d[b] = tx;
               end
`ifdef UART_PARITY_EN
               repeat (e.period) @(negedge clk);
               check("rx_parity_bit", tx, ^e.data);
`endif
               repeat (e.period) @(negedge clk);
               check("rx_stop_bit", tx, 1);
               check("rx_byte", d, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time %0t exceeded bound", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      setv(0,  BASE + 32'h8,  1'b0, 32'd0,         32'd433, "rd_baud_reset");
      setv(1,  BASE + 32'h4,  1'b0, 32'd0,         32'd0,   "rd_status_reset");
      setv(2,  BASE + 32'h0,  1'b0, 32'd0,         32'd0,   "rd_txdata_zero");
      setv(3,  BASE + 32'hC,  1'b0, 32'd0,         32'd0,   "rd_unmapped_c");
      setv(4,  BASE + 32'h10, 1'b0, 32'd0,         32'd0,   "rd_outside_10");
      setv(5,  BASE + 32'h8,  1'b1, 32'hABCD_0003, 32'd0,   "wr_baud");
      setv(6,  BASE + 32'h8,  1'b0, 32'd0,         32'd3,   "rd_baud_written");
      setv(7,  BASE + 32'hB,  1'b0, 32'd0,         32'd3,   "rd_baud_low_bits");
      setv(8,  BASE + 32'hC,  1'b1, 32'h0000_00FF, 32'd0,   "wr_unmapped_c");
      setv(9,  BASE + 32'h18, 1'b1, 32'h0000_0009, 32'd0,   "wr_outside_18");
      setv(10, BASE + 32'h8,  1'b0, 32'd0,         32'd3,   "rd_baud_after_stray");
      setv(11, BASE + 32'h4,  1'b0, 32'd0,         32'd0,   "rd_status_after_stray");
      setv(12, 32'h0000_0008, 1'b0, 32'd0,         32'd0,   "rd_low_addr");

      rst      = 1'b0;
      HADDR    = 32'd0;
      HWDATA   = 32'd0;
      MemWrite = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", tx, 1);
      check("reset_busy", tx_busy, 0);
      rd(BASE + 32'h8, 32'd433, "reset_baud_in_reset");
      rst = 1'b1;
      step();

      for (int i = 0; i < 13; i++) begin
         if (vt[i].wr) wr(vt[i].addr, vt[i].wdata);
         else rd(vt[i].addr, vt[i].exp, vt[i].nm);
      end

      // Single frame 0x55 at BAUDDIV=3
      runs.delete();
      send(8'h55, 4, 1'b1);
      rd(BASE + 32'h4, 32'h2, "f55_status_hold");
      push_frame(8'h55, 4);
      check_wave("f55", 1);
      get_run("f55_busy_run", FRAME_BITS * 4);

      // Back-to-back stores
      runs.delete();
      send(8'hA5, 4, 1'b1);
      send(8'h3C, 4, 1'b1);
      rd(BASE + 32'h4, 32'h3, "b2b_status");
      push_frame(8'hA5, 4);
      push_frame(8'h3C, 4);
      check_wave("b2b", 0);
      get_run("b2b_busy_run", FRAME_BITS * 8);

      // Overrun: third byte dropped
      runs.delete();
      send(8'h11, 4, 1'b1);
      send(8'h22, 4, 1'b1);
      send(8'h33, 4, 1'b0);
      rd(BASE + 32'h4, 32'h7, "ovr_status_set");
      wr(BASE + 32'h4, 32'h4);
      rd(BASE + 32'h4, 32'h3, "ovr_status_cleared");
      wait_idle("ovr", 400);
      get_run("ovr_busy_run", FRAME_BITS * 8);
      check("ovr_sb_empty", sb.size(), 0);

      // BAUDDIV change mid-frame
      runs.delete();
      send(8'h96, 4, 1'b1);
      repeat (12) step();
      wr(BASE + 32'h8, 32'd7);
      send(8'h69, 8, 1'b1);
      rd(BASE + 32'h8, 32'd7, "mid_baud_rd");
      wait_idle("mid", 600);
      get_run("mid_busy_run", FRAME_BITS * 4 + FRAME_BITS * 8);

      // BAUDDIV=1, byte 0x07 (parity bit 1 when enabled)
      wr(BASE + 32'h8, 32'd1);
      runs.delete();
      send(8'h07, 2, 1'b1);
      push_frame(8'h07, 2);
      check_wave("f07", 1);
      get_run("f07_busy_run", FRAME_BITS * 2);
      rd(BASE + 32'h10, 32'd0, "rd_base_plus_10");

      // Reset in the middle of a frame
      wr(BASE + 32'h8, 32'd3);
      rx_mute = 1'b1;
      wr(BASE, 32'h0000_0000);
      repeat (10) step();
      check("pre_abort_busy", tx_busy, 1);
      check("pre_abort_tx", tx, 0);
      rst = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_busy", tx_busy, 0);
      rd(BASE + 32'h8, 32'd433, "abort_baud");
      rd(BASE + 32'h4, 32'd0, "abort_status");
      step();
      rst = 1'b1;
      repeat (5) step();
      check("abort_stays_idle", tx_busy, 0);
      check("abort_tx_high", tx, 1);
      rx_mute = 1'b0;

      check("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
